// File: rtl/matrix_mem_pkg.sv
// Shared constants, clear-sequencer state encoding and lane-mask helper
// for the matrix row memory.
package matrix_mem_pkg;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_LANE_W = 16;
    localparam int DEF_LANES  = 16;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_ADDR_W = 8;

    // Widest lane mask the helper accepts; callers zero-extend into it.
    localparam int MAX_LANES  = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Write-enable of data bit bit_idx, given the per-lane mask.
    function automatic logic lane_bit(input logic [MAX_LANES-1:0] lane_mask,
                                      input int bit_idx, input int lane_w);
        logic b;
        b = 1'b0;
        if ((bit_idx / lane_w) < MAX_LANES) begin
            b = lane_mask[8'(bit_idx / lane_w)];
        end
        return b;
    endfunction

endpackage

// File: rtl/matrix_mem_clear_seq.sv
// Clear sequencer: walks every row writing zero after reset or on request,
// and reports busy while it owns the array.
module matrix_mem_clear_seq
    import matrix_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o,
    output logic              state_o
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                clr_we_o = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign clr_addr_o = ptr_q;
    assign busy_o     = (state_q == ST_CLEAR);
    assign state_o    = state_q;

endmodule

// File: rtl/matrix_mem_1r1w.sv
// Row memory with independent read and write ports, per-lane write mask,
// registered read with valid strobe, optional read-during-write bypass.
module matrix_mem_1r1w
    import matrix_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANE_W = DEF_LANE_W,
    parameter int LANES  = DEF_LANES,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LANES-1:0]  wr_mask_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              busy_o
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_busy;
    logic              clr_state;

    matrix_mem_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (clr_busy),
        .state_o    (clr_state)
    );

    assign busy_o = clr_busy;

    // User ports only reach the array while the sequencer is idle.
    logic port_en, wr_fire, rd_fire;
    assign port_en = (clr_state == ST_IDLE);
    assign wr_fire = wr_en_i & port_en;
    assign rd_fire = rd_en_i & port_en;

    logic [MAX_LANES-1:0] mask_ext;
    logic [DATA_W-1:0]    bit_mask;

    always_comb begin
        mask_ext             = '0;
        mask_ext[LANES-1:0]  = wr_mask_i;
        bit_mask             = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bit_mask[i] = lane_bit(mask_ext, i, LANE_W);
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wr_row_new, rd_row_old;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        wr_row_new = (mem_q[wr_addr_i] & ~bit_mask) | (wr_data_i & bit_mask);
        rd_row_old = mem_q[rd_addr_i];
        mem_we     = clr_we | wr_fire;
        mem_waddr  = clr_we ? clr_addr : wr_addr_i;
        mem_wdata  = clr_we ? '0 : wr_row_new;
    end

    // Array contents are deliberately not reset; the clear sequence zeroes them.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_fire;
        if (rd_fire) begin
            if (BYPASS && wr_fire && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_row_new;
            end else begin
                rd_data_d = rd_row_old;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_matrix_mem_1r1w.sv
// Scoreboard bench for matrix_mem_1r1w: one bypass and one non-bypass
// instance share stimulus; a negedge monitor checks every read return.
module tb_matrix_mem_1r1w;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         clr_i = 1'b0;
    logic         wr_en_i = 1'b0;
    logic [7:0]   wr_addr_i = '0;
    logic [15:0]  wr_mask_i = '0;
    logic [255:0] wr_data_i = '0;
    logic         rd_en_i = 1'b0;
    logic [7:0]   rd_addr_i = '0;

    logic [255:0] rd_data_b, rd_data_n;
    logic         rd_valid_b, rd_valid_n;
    logic         busy_b, busy_n;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [255:0] exp_q_b[$];
    logic [255:0] exp_q_n[$];
    int           cyc_q_b[$];
    int           cyc_q_n[$];

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_mem_1r1w #(.BYPASS(1'b1)) u_dut_byp (
        .clk_i (clk), .rst_i (rst_i), .clr_i (clr_i),
        .wr_en_i (wr_en_i), .wr_addr_i (wr_addr_i), .wr_mask_i (wr_mask_i),
        .wr_data_i (wr_data_i), .rd_en_i (rd_en_i), .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_b), .rd_valid_o (rd_valid_b), .busy_o (busy_b)
    );

    matrix_mem_1r1w #(.BYPASS(1'b0)) u_dut_nobyp (
        .clk_i (clk), .rst_i (rst_i), .clr_i (clr_i),
        .wr_en_i (wr_en_i), .wr_addr_i (wr_addr_i), .wr_mask_i (wr_mask_i),
        .wr_data_i (wr_data_i), .rd_en_i (rd_en_i), .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_n), .rd_valid_o (rd_valid_n), .busy_o (busy_n)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    task automatic mon(input bit byp, input logic v, input logic [255:0] a);
        logic [255:0] e;
        int           c;
        if (v === 1'b1) begin
            if ((byp && exp_q_b.size() == 0) || (!byp && exp_q_n.size() == 0)) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid %s got valid=1 exp valid=0 at cycle %0d",
                         byp ? "byp" : "nobyp", cyc);
            end else begin
                if (byp) begin
                    e = exp_q_b.pop_front();
                    c = cyc_q_b.pop_front();
                end else begin
                    e = exp_q_n.pop_front();
                    c = cyc_q_n.pop_front();
                end
                chk(byp ? "rd_data_byp" : "rd_data_nobyp", a, e);
                chk(byp ? "rd_cycle_byp" : "rd_cycle_nobyp", 256'(cyc), 256'(c));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b1, rd_valid_b, rd_data_b);
        mon(1'b0, rd_valid_n, rd_data_n);
    end

    // driver: one clock of stimulus; e_b/e_n are the expected read returns
    task automatic cycle(input logic we, input logic [7:0] wa, input logic [15:0] wm,
                         input logic [255:0] wd, input logic re, input logic [7:0] ra,
                         input logic [255:0] e_b, input logic [255:0] e_n);
        wr_en_i   = we;
        wr_addr_i = wa;
        wr_mask_i = wm;
        wr_data_i = wd;
        rd_en_i   = re;
        rd_addr_i = ra;
        if (re) begin
            exp_q_b.push_back(e_b);
            exp_q_n.push_back(e_n);
            cyc_q_b.push_back(cyc + 1);
            cyc_q_n.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    // Counts busy cycles of both instances; drops wr/rd after poke busy cycles.
    task automatic measure_busy(input string nm, input int poke);
        int nb = 0;
        int nn = 0;
        int guard = 0;
        bit done = 1'b0;
        while (!done && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (busy_b === 1'b1) nb++;
            if (busy_n === 1'b1) nn++;
            if (busy_b !== 1'b1 && busy_n !== 1'b1) done = 1'b1;
            if (poke > 0 && nb == poke) begin
                wr_en_i = 1'b0;
                rd_en_i = 1'b0;
            end
        end
        chk({nm, "_busy_len_byp"}, 256'(nb), 256'd256);
        chk({nm, "_busy_len_nobyp"}, 256'(nn), 256'd256);
    endtask

    task automatic reset_and_measure(input string nm);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk({nm, "_rst_busy_byp"}, 256'(busy_b), 256'd1);
        chk({nm, "_rst_busy_nobyp"}, 256'(busy_n), 256'd1);
        chk({nm, "_rst_valid_byp"}, 256'(rd_valid_b), 256'd0);
        chk({nm, "_rst_valid_nobyp"}, 256'(rd_valid_n), 256'd0);
        chk({nm, "_rst_data_byp"}, rd_data_b, 256'd0);
        chk({nm, "_rst_data_nobyp"}, rd_data_n, 256'd0);
        measure_busy(nm, 0);
    endtask

    task automatic read_all_zero();
        for (int r = 0; r < 256; r++) begin
            cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'(r), '0, '0);
        end
    endtask

    task automatic fill_all();
        for (int r = 0; r < 256; r++) begin
            cycle(1'b1, 8'(r), 16'hFFFF, {16{8'(r), 8'hC3}}, 1'b0, 8'h00, '0, '0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // reset, then every row reads zero
        reset_and_measure("init");
        read_all_zero();

        // masked write
        cycle(1'b1, 8'h10, 16'hFFFF, {16{16'hFFFF}}, 1'b0, 8'h00, '0, '0);
        cycle(1'b1, 8'h10, 16'h0001, {16{16'h1234}}, 1'b0, 8'h00, '0, '0);
        cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'h10,
              {{15{16'hFFFF}}, 16'h1234}, {{15{16'hFFFF}}, 16'h1234});

        // read-during-write to the same row
        cycle(1'b1, 8'h20, 16'hFFFF, {16{16'hAAAA}}, 1'b0, 8'h00, '0, '0);
        cycle(1'b1, 8'h20, 16'h00FF, {16{16'h5555}}, 1'b1, 8'h20,
              {{8{16'hAAAA}}, {8{16'h5555}}}, {16{16'hAAAA}});
        cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'h20,
              {{8{16'hAAAA}}, {8{16'h5555}}}, {{8{16'hAAAA}}, {8{16'h5555}}});

        // back-to-back reads with concurrent writes to other rows
        cycle(1'b1, 8'h01, 16'hFFFF, {16{16'h0101}}, 1'b0, 8'h00, '0, '0);
        cycle(1'b1, 8'h02, 16'hFFFF, {16{16'h0202}}, 1'b0, 8'h00, '0, '0);
        cycle(1'b1, 8'h03, 16'hFFFF, {16{16'h0303}}, 1'b0, 8'h00, '0, '0);
        cycle(1'b1, 8'h04, 16'hFFFF, {16{16'h0404}}, 1'b1, 8'h01, {16{16'h0101}}, {16{16'h0101}});
        cycle(1'b1, 8'h05, 16'hFFFF, {16{16'h0505}}, 1'b1, 8'h02, {16{16'h0202}}, {16{16'h0202}});
        cycle(1'b1, 8'h06, 16'hFFFF, {16{16'h0606}}, 1'b1, 8'h03, {16{16'h0303}}, {16{16'h0303}});
        cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'h04, {16{16'h0404}}, {16{16'h0404}});
        cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'h05, {16{16'h0505}}, {16{16'h0505}});
        cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'h06, {16{16'h0606}}, {16{16'h0606}});
        // all-zero mask leaves the row untouched
        cycle(1'b1, 8'h06, 16'h0000, {16{16'hDEAD}}, 1'b0, 8'h00, '0, '0);
        cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'h06, {16{16'h0606}}, {16{16'h0606}});

        // clear request; the read in the request cycle is still serviced
        fill_all();
        clr_i = 1'b1;
        cycle(1'b0, 8'h00, 16'h0000, '0, 1'b1, 8'h05, {16{8'h05, 8'hC3}}, {16{8'h05, 8'hC3}});
        wr_en_i   = 1'b1;
        wr_addr_i = 8'h33;
        wr_mask_i = 16'hFFFF;
        wr_data_i = {16{16'hBEEF}};
        rd_en_i   = 1'b1;
        rd_addr_i = 8'h33;
        measure_busy("clr", 4);
        @(posedge clk);
        #1;
        read_all_zero();

        // reset in the middle of a clear restarts it
        fill_all();
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        reset_and_measure("midclr");
        read_all_zero();

        repeat (3) @(posedge clk);
        #1;
        chk("drain_byp", 256'(exp_q_b.size()), 256'd0);
        chk("drain_nobyp", 256'(exp_q_n.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
